// File: rtl/neuro_cfg_loader_pkg.sv
// Shared types and constants for the neuron configuration-chain loader.
package neuro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHIFT,
    DONE,
    ERR
  } state_e;

  localparam int W_WIDTH    = 3;
  localparam int TSEL_WIDTH = 3;
  localparam int U_WIDTH    = 5;

  // Frame layout per neuron: wA, wB, wC, tSel, U
  localparam int BITS_PER_NEURON = 3 * W_WIDTH + TSEL_WIDTH + U_WIDTH;

  function automatic int bytes_for_bits(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/neuro_cfg_loader_if.sv
// Host byte stream into the loader: valid/ready handshake, byte transfers on valid && ready.
interface neuro_cfg_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/neuro_cfg_loader_rb_packer.sv
// Packs chain-tail bits MSB-first into readback bytes; a final partial byte is left-aligned.
module neuro_rb_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       bit_i,
  input  logic       last_i,
  input  logic       abort_i,
  output logic [7:0] rb_byte_o,
  output logic       rb_valid_o
);

  logic [6:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic [7:0] full;

  always_comb begin
    full    = {acc_q, bit_i};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    if (en_i) begin
      acc_d = full[6:0];
      if (cnt_q == 3'd7) begin
        byte_d  = full;
        valid_d = 1'b1;
        cnt_d   = 3'd0;
      end else if (last_i) begin
        // stale bits above the partial byte are shifted out the top
        byte_d  = full << (3'd7 - cnt_q);
        valid_d = 1'b1;
        cnt_d   = 3'd0;
      end else if (abort_i) begin
        cnt_d = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign rb_byte_o  = byte_q;
  assign rb_valid_o = valid_q;

endmodule

// File: rtl/neuro_cfg_loader.sv
// Serialises host configuration bytes onto the neuron configuration chain.
// Readback packer is built only with NEURO_CFG_READBACK_EN defined.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | waiting for the first byte
// SHIFT | one chain bit per cycle, next byte buffered in the holding register
// DONE  | one-cycle completion pulse
// ERR   | underrun; err set, back to IDLE
module neuro_cfg_loader #(
  parameter int N_NEURONS       = 1,
  parameter int BITS_PER_NEURON = neuro_pkg::BITS_PER_NEURON
) (
  input  logic                clk,
  input  logic                nn_reset,
  input  logic                start,
  neuro_cfg_loader_if.slave   host,
  output logic                conf_en,
  output logic                cfg_bs,
  input  logic                bs_out,
  output logic [7:0]          rb_byte,
  output logic                rb_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import neuro_pkg::*;

  localparam int NBITS  = N_NEURONS * BITS_PER_NEURON;
  localparam int NBYTES = bytes_for_bits(NBITS);
  localparam int PAD    = 8 * NBYTES - NBITS;
  localparam int REM_W  = $clog2(NBITS + 1);
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [2:0] PAD_PTR = 3'(PAD);

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic             err_q, err_d;

  logic byte_ready_c;
  logic accept;
  logic shift_last;
  logic shift_abort;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    taken_d      = taken_q;
    err_d        = err_q;
    byte_ready_c = 1'b0;
    accept       = 1'b0;
    conf_en      = 1'b0;
    cfg_bs       = 1'b0;
    done         = 1'b0;
    shift_last   = 1'b0;
    shift_abort  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          err_d   = 1'b0;
        end
      end
      FILL: begin
        byte_ready_c = 1'b1;
        if (host.byte_valid) begin
          shift_d = host.byte_in;
          ptr_d   = PAD_PTR;
          rem_d   = REM_W'(NBITS);
          taken_d = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        conf_en      = 1'b1;
        cfg_bs       = shift_q[3'd7 - ptr_q];
        byte_ready_c = !hold_vld_q && (taken_q < CNT_W'(NBYTES));
        accept       = byte_ready_c && host.byte_valid;
        ptr_d        = ptr_q + 3'd1;
        rem_d        = rem_q - REM_W'(1);
        if (accept) begin
          hold_d     = host.byte_in;
          hold_vld_d = 1'b1;
          taken_d    = taken_q + CNT_W'(1);
        end
        if (rem_q == REM_W'(1)) begin
          shift_last = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = DONE;
        end else if (ptr_q == 3'd7) begin
          // a byte arriving on the wrap edge goes straight into the shifter
          if (hold_vld_q) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
          end else if (accept) begin
            shift_d    = host.byte_in;
            hold_vld_d = 1'b0;
          end else begin
            shift_abort = 1'b1;
            err_d       = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nn_reset) begin
    if (nn_reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ptr_q      <= '0;
      rem_q      <= '0;
      taken_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      taken_q    <= taken_d;
      err_q      <= err_d;
    end
  end

  assign host.byte_ready = byte_ready_c;
  assign busy            = (state_q != IDLE);
  assign err             = err_q;

`ifdef NEURO_CFG_READBACK_EN
  neuro_rb_packer u_rb_packer (
    .clk        (clk),
    .rst        (nn_reset),
    .en_i       (conf_en),
    .bit_i      (bs_out),
    .last_i     (shift_last),
    .abort_i    (shift_abort),
    .rb_byte_o  (rb_byte),
    .rb_valid_o (rb_valid)
  );
`else
  logic unused_rb;
  assign unused_rb = bs_out ^ shift_last ^ shift_abort;
  assign rb_byte   = 8'h00;
  assign rb_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_neuro_cfg_loader.sv
// Directed bench for neuro_cfg_loader (N_NEURONS=1, 17-bit chain).
module tb_neuro_cfg_loader;

`ifdef NEURO_CFG_READBACK_EN
  localparam int RB_STROBES = 3;
`else
  localparam int RB_STROBES = 0;
`endif

  logic        clk = 1'b0;
  logic        nn_reset;
  logic        start;
  logic        conf_en, cfg_bs, bs_out;
  logic [7:0]  rb_byte;
  logic        rb_valid, busy, done, err;
  logic [16:0] chain;
  logic        chain_load;

  neuro_cfg_loader_if bif ();

  neuro_cfg_loader #(.N_NEURONS(1)) dut (
    .clk      (clk),
    .nn_reset (nn_reset),
    .start    (start),
    .host     (bif),
    .conf_en  (conf_en),
    .cfg_bs   (cfg_bs),
    .bs_out   (bs_out),
    .rb_byte  (rb_byte),
    .rb_valid (rb_valid),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // behavioural 17-bit chain, tail feeds bs_out
  always @(posedge clk) begin
    if (chain_load) chain <= 17'h1FFFF;
    else if (conf_en) chain <= {chain[15:0], cfg_bs};
  end
  assign bs_out = chain[16];

  int checks = 0;
  int errors = 0;

  logic [31:0] bits_q;
  int en_cnt, first_en, last_en, done_cnt, done_cyc, rb_cnt, idx_final;
  bit gap_seen, err_drop, busy_drop, rb_in_done;
  logic [7:0] rb_log [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [31:0] bytes, input int nb,
                          input logic [39:0] vmask, input bit pulse_start);
    int idx;
    bit hs, dropped;
    idx = 0; dropped = 0; bits_q = '0; en_cnt = 0; first_en = -1; last_en = -1;
    done_cnt = 0; done_cyc = -1; gap_seen = 0; err_drop = 0; busy_drop = 1;
    rb_cnt = 0; rb_in_done = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_in_fill", 32'(bif.byte_ready), 32'd1);
    check("err_clear_on_start", 32'(err), 32'd0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      bif.byte_valid = (idx < nb) && vmask[cyc];
      bif.byte_in    = bif.byte_valid ? bytes[31 - 8 * idx -: 8] : 8'($urandom);
      start          = pulse_start && (cyc == 5);
      hs             = bif.byte_valid && bif.byte_ready;
      tick;
      start = 1'b0;
      if (hs) idx++;
      if (conf_en) begin
        if (dropped) gap_seen = 1;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
        bits_q = {bits_q[30:0], cfg_bs};
      end else if (en_cnt > 0 && !dropped) begin
        dropped   = 1;
        err_drop  = err;
        busy_drop = busy;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rb_valid) begin
        if (rb_cnt < 4) rb_log[rb_cnt] = rb_byte;
        rb_cnt++;
        if (done) rb_in_done = 1;
      end
    end
    bif.byte_valid = 1'b0;
    idx_final = idx;
  endtask

  initial begin
    nn_reset = 1'b1; start = 1'b0; chain_load = 1'b1;
    bif.byte_valid = 1'b0; bif.byte_in = 8'h00;
    tick; tick;
    check("rst_conf_en", 32'(conf_en), 32'd0);
    check("rst_cfg_bs", 32'(cfg_bs), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(bif.byte_ready), 32'd0);
    check("rst_rb", {23'd0, rb_valid, rb_byte}, 32'd0);
    nn_reset = 1'b0; chain_load = 1'b0;
    tick;

    // nominal load, a fourth byte is offered but must never be taken
    run_load(32'h01234599, 4, '1, 1'b0);
    check("t1_bits", bits_q, 32'h12345);
    check("t1_en_cnt", 32'(en_cnt), 32'd17);
    check("t1_first_en", 32'(first_en), 32'd0);
    check("t1_contig", 32'(gap_seen), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_cyc", 32'(done_cyc), 32'd17);
    check("t1_err", 32'(err), 32'd0);
    check("t1_bytes_taken", 32'(idx_final), 32'd3);
    check("t1_rb_strobes", 32'(rb_cnt), 32'(RB_STROBES));
    check("t1_idle_ready", 32'(bif.byte_ready), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // underrun: only two bytes
    run_load(32'h01230000, 2, '1, 1'b0);
    check("t2_bits", bits_q, 32'h123);
    check("t2_en_cnt", 32'(en_cnt), 32'd9);
    check("t2_err_at_drop", 32'(err_drop), 32'd1);
    check("t2_busy_at_drop", 32'(busy_drop), 32'd0);
    check("t2_no_done", 32'(done_cnt), 32'd0);
    check("t2_err_sticky", 32'(err), 32'd1);

    // backpressure: 1-cycle gaps once the shifter is running; also clears err
    run_load(32'hABCDEF00, 3, 40'hAA_AAAA_AAAB, 1'b0);
    check("t3_bits", bits_q, 32'h1CDEF);
    check("t3_en_cnt", 32'(en_cnt), 32'd17);
    check("t3_contig", 32'(gap_seen), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_err", 32'(err), 32'd0);

    // third byte arrives exactly on the wrap edge
    run_load(32'h5A3C9600, 3, 40'h00_0000_0203, 1'b0);
    check("t4_bits", bits_q, 32'h03C96);
    check("t4_en_cnt", 32'(en_cnt), 32'd17);
    check("t4_contig", 32'(gap_seen), 32'd0);
    check("t4_err", 32'(err), 32'd0);

    // start pulsed mid-SHIFT is ignored
    run_load(32'h01234500, 3, '1, 1'b1);
    check("t5_bits", bits_q, 32'h12345);
    check("t5_en_cnt", 32'(en_cnt), 32'd17);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_busy_end", 32'(busy), 32'd0);

    // asynchronous reset mid-SHIFT
    start = 1'b1; tick; start = 1'b0;
    bif.byte_valid = 1'b1; bif.byte_in = 8'h01; tick;
    bif.byte_in = 8'h23; tick;
    bif.byte_valid = 1'b0; tick; tick;
    check("t6_shifting", 32'(conf_en), 32'd1);
    #2 nn_reset = 1'b1;
    #1;
    check("t6_rst_conf_en", 32'(conf_en), 32'd0);
    check("t6_rst_cfg_bs", 32'(cfg_bs), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(bif.byte_ready), 32'd0);
    check("t6_rst_flags", {29'd0, done, err, rb_valid}, 32'd0);
    #2 nn_reset = 1'b0;
    tick;
    check("t6_idle_after", 32'(busy), 32'd0);
    run_load(32'h01234500, 3, '1, 1'b0);
    check("t6_reload_bits", bits_q, 32'h12345);
    check("t6_reload_done", 32'(done_cnt), 32'd1);

`ifdef NEURO_CFG_READBACK_EN
    chain_load = 1'b1; tick; chain_load = 1'b0;
    run_load(32'h00000000, 3, '1, 1'b0);
    check("t7_rb_cnt", 32'(rb_cnt), 32'd3);
    check("t7_rb0", 32'(rb_log[0]), 32'hFF);
    check("t7_rb1", 32'(rb_log[1]), 32'hFF);
    check("t7_rb2", 32'(rb_log[2]), 32'h80);
    check("t7_rb_in_done", 32'(rb_in_done), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
